health_manager: RTL and testbench
=================================

Name: health_manager

Overview:
- Per-player health state keeper that sits directly upstream of the health bar renderer and drives its 9-bit current-health input.
- Accepts hit requests from the collision/combat logic through a valid/ready handshake.
- Applies block-reduced damage with saturation at zero, enforces an invulnerability window after each hit, and flags knock-out.
- Restores full health on a round-start pulse.

Parameters:
- FULL_HEALTH, 200, health value loaded at reset and at round start; must be ≤ 511.
- INVULN_CYCLES, 25_000_000, clk cycles of hit immunity after a non-lethal hit; must be ≥ 1.
- REGEN_DELAY, 100_000_000, cycles without an accepted hit before regeneration begins (optional feature only).
- REGEN_PERIOD, 12_500_000, cycles between +1 regeneration steps (optional feature only).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- new_round  input  1  single-cycle pulse: restore health and clear state
- hit_valid  input  1  hit request present
- hit_damage  input  8  raw damage of the request
- blocking  input  1  defender is blocking; sampled together with the accepted hit
- hit_ready  output  1  hit can be accepted this cycle
- curr_health  output  9  current health, feeds the health bar
- hit_taken  output  1  one-cycle pulse, the cycle after a hit is accepted
- invuln  output  1  high while in INVULN
- ko  output  1  high while in KO

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state=ALIVE, curr_health=FULL_HEALTH, hit_taken=0, invuln=0, ko=0, invulnerability counter=0, regen counters=0.
- States: ALIVE, INVULN, KO. Encoding is free.
- hit_ready is combinational and equals (state==ALIVE && !new_round).
- Acceptance: a hit is accepted on a rising edge when hit_valid && hit_ready. There is no buffering; a hit presented while hit_ready=0 is ignored, and the requester may drop it.
- Effective damage: eff = blocking ? (hit_damage >> 1) : hit_damage. This is 8-bit and zero-extended to 9 bits.
- Health update (1-cycle latency): on the acceptance edge, curr_health <= (curr_health > eff) ? curr_health - eff : 0. No underflow wrap.
- hit_taken pulses high for exactly the cycle following every accepted hit, including eff=0 and lethal hits.
- State transitions on an accepted hit:
  - Resulting health == 0 → KO.
  - Otherwise → INVULN, with the counter loaded to INVULN_CYCLES-1.
- INVULN: the counter decrements each cycle. At 0 the state returns to ALIVE on the next edge, so hit_ready is low for exactly INVULN_CYCLES cycles after the acceptance edge.
- KO: absorbing state. curr_health is held at 0 and hit_ready=0. Only new_round or reset leaves it.
- new_round has the highest priority in every state:
  - curr_health <= FULL_HEALTH, state <= ALIVE, all counters cleared, no hit_taken.
  - A hit_valid in the same cycle is not accepted (hit_ready is already low).
- Output mapping: invuln = (state==INVULN) and ko = (state==KO). Both are registered-state derived, with no combinational path from inputs.
- Zero-damage hit (eff=0, e.g. damage 1 while blocking): health is unchanged, but the block still enters INVULN and pulses hit_taken.
- Reset asserted mid-INVULN or in KO returns all outputs to their reset values immediately (asynchronously).

Optional Feature:
- Macro: HEALTH_REGEN_EN.
- Defined:
  - A quiet counter runs while state==ALIVE and curr_health < FULL_HEALTH. It is cleared by any accepted hit, by new_round, and on entry to KO.
  - Once the quiet counter reaches REGEN_DELAY, curr_health increments by 1 every REGEN_PERIOD cycles and saturates at FULL_HEALTH.
  - No regeneration in INVULN or KO.
  - An accepted hit in the same cycle as a regen step takes precedence; the regen step is discarded.
- Undefined: no regen logic or counters are synthesised. curr_health changes only on hits, new_round, and reset.

Test Plan (bench overrides INVULN_CYCLES=4, REGEN_DELAY=8, REGEN_PERIOD=2):
- Reset then release rst_n → curr_health=200, hit_ready=1, ko=0, invuln=0.
- hit_valid=1, damage=30, blocking=0 → next cycle curr_health=170 and hit_taken=1 for 1 cycle; hit_ready low for exactly 4 cycles, then 1; a hit_valid held during the window is ignored.
- damage=31, blocking=1 from 170 → curr_health=155.
- From 20, damage=255 → curr_health=0, ko=1, hit_ready stays 0. Then new_round pulse → curr_health=200, ko=0, hit_ready=1.
- new_round and hit_valid (damage 50) in the same cycle while ALIVE at 100 → curr_health=200, no hit_taken.
- With HEALTH_REGEN_EN, hit to 190 then idle → after INVULN plus 8 quiet cycles, +1 every 2 cycles, stopping at 200. A hit mid-regen clears the quiet counter.

Source files
------------

// File: rtl/health_manager.sv
// Per-player health keeper: block-reduced damage, post-hit invulnerability and knock-out.
// Define HEALTH_REGEN_EN to add idle-time health regeneration.
module health_manager #(
    parameter int unsigned FULL_HEALTH   = 200,
    parameter int unsigned INVULN_CYCLES = 25_000_000,
    parameter int unsigned REGEN_DELAY   = 100_000_000,
    parameter int unsigned REGEN_PERIOD  = 12_500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       new_round,
    input  logic       hit_valid,
    input  logic [7:0] hit_damage,
    input  logic       blocking,
    output logic       hit_ready,
    output logic [8:0] curr_health,
    output logic       hit_taken,
    output logic       invuln,
    output logic       ko
);

    localparam int unsigned IW = (INVULN_CYCLES > 1) ? $clog2(INVULN_CYCLES) : 1;
    localparam logic [8:0]    FULL     = 9'(FULL_HEALTH);
    localparam logic [IW-1:0] INV_LOAD = IW'(INVULN_CYCLES - 1);

    if (FULL_HEALTH > 511 || INVULN_CYCLES == 0 || REGEN_PERIOD == 0 || REGEN_DELAY == 0) begin : g_param_check
        $error("health_manager: parameter out of range");
    end

    typedef enum logic [1:0] {ST_ALIVE, ST_INVULN, ST_KO} state_t;

    state_t        r_state, w_state_nxt;
    logic [8:0]    r_health, w_health_nxt;
    logic [IW-1:0] r_inv_cnt, w_inv_cnt_nxt;
    logic          r_hit_taken;
    logic          w_accept;
    logic          w_regen_step;
    logic [8:0]    w_eff;
    logic [8:0]    w_hit_health;

    assign hit_ready    = (r_state == ST_ALIVE) && !new_round;
    assign w_accept     = hit_valid && hit_ready;
    assign w_eff        = {1'b0, blocking ? {1'b0, hit_damage[7:1]} : hit_damage};
    assign w_hit_health = (r_health > w_eff) ? (r_health - w_eff) : '0;

`ifdef HEALTH_REGEN_EN
    localparam int unsigned QW = $clog2(REGEN_DELAY + 1);
    localparam int unsigned PW = (REGEN_PERIOD > 1) ? $clog2(REGEN_PERIOD) : 1;
    localparam logic [QW-1:0] QMAX = QW'(REGEN_DELAY);
    localparam logic [PW-1:0] PMAX = PW'(REGEN_PERIOD - 1);

    logic [QW-1:0] r_quiet;
    logic [PW-1:0] r_period;
    logic          w_quiet_run;

    // Any condition that stops the quiet run (hit, new_round, KO, full health) restarts it from zero.
    assign w_quiet_run  = (r_state == ST_ALIVE) && (r_health < FULL) && !w_accept && !new_round;
    assign w_regen_step = w_quiet_run && (r_quiet == QMAX) && (r_period == PMAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_quiet  <= '0;
            r_period <= '0;
        end else if (!w_quiet_run) begin
            r_quiet  <= '0;
            r_period <= '0;
        end else if (r_quiet != QMAX) begin
            r_quiet  <= r_quiet + 1'b1;
        end else if (r_period == PMAX) begin
            r_period <= '0;
        end else begin
            r_period <= r_period + 1'b1;
        end
    end
`else
    assign w_regen_step = 1'b0;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_health_nxt  = r_health;
        w_inv_cnt_nxt = r_inv_cnt;
        if (new_round) begin
            w_state_nxt   = ST_ALIVE;
            w_health_nxt  = FULL;
            w_inv_cnt_nxt = '0;
        end else begin
            case (r_state)
                ST_ALIVE: begin
                    if (w_accept) begin
                        w_health_nxt = w_hit_health;
                        if (w_hit_health == '0) begin
                            w_state_nxt = ST_KO;
                        end else begin
                            w_state_nxt   = ST_INVULN;
                            w_inv_cnt_nxt = INV_LOAD;
                        end
                    end else if (w_regen_step) begin
                        w_health_nxt = r_health + 9'd1;
                    end
                end
                ST_INVULN: begin
                    if (r_inv_cnt == '0) begin
                        w_state_nxt = ST_ALIVE;
                    end else begin
                        w_inv_cnt_nxt = r_inv_cnt - 1'b1;
                    end
                end
                ST_KO: begin
                    w_health_nxt = '0;
                end
                default: begin
                    w_state_nxt = ST_ALIVE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ALIVE;
            r_health    <= FULL;
            r_inv_cnt   <= '0;
            r_hit_taken <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_health    <= w_health_nxt;
            r_inv_cnt   <= w_inv_cnt_nxt;
            r_hit_taken <= w_accept;
        end
    end

    assign curr_health = r_health;
    assign hit_taken   = r_hit_taken;
    assign invuln      = (r_state == ST_INVULN);
    assign ko          = (r_state == ST_KO);

endmodule

// File: tb/tb_health_manager.sv
// Randomized scoreboard bench for health_manager against a cycle-level behavioural model.
module tb_health_manager;

    localparam int unsigned FULL = 200;
    localparam int unsigned INV  = 4;
    localparam int unsigned RD   = 8;
    localparam int unsigned RP   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       new_round;
    logic       hit_valid;
    logic [7:0] hit_damage;
    logic       blocking;
    logic       hit_ready;
    logic [8:0] curr_health;
    logic       hit_taken;
    logic       invuln;
    logic       ko;

    health_manager #(
        .FULL_HEALTH  (FULL),
        .INVULN_CYCLES(INV),
        .REGEN_DELAY  (RD),
        .REGEN_PERIOD (RP)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .new_round  (new_round),
        .hit_valid  (hit_valid),
        .hit_damage (hit_damage),
        .blocking   (blocking),
        .hit_ready  (hit_ready),
        .curr_health(curr_health),
        .hit_taken  (hit_taken),
        .invuln     (invuln),
        .ko         (ko)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int health;
        int ko;
    } exp_t;
    exp_t sb_q[$];

    // Model: health value, cycles of lockout remaining, knocked-out flag
    int m_health;
    int m_lock;
    int m_ko;
    int m_taken;
`ifdef HEALTH_REGEN_EN
    int m_quiet;
`endif

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_health = FULL;
        m_lock   = 0;
        m_ko     = 0;
        m_taken  = 0;
`ifdef HEALTH_REGEN_EN
        m_quiet  = 0;
`endif
    endtask

    // Monitor: every hit_taken pulse must match the oldest pending expected hit result
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && hit_taken) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_hit_taken: got pulse, expected none (t=%0t)", $time);
            end else begin
                e = sb_q.pop_front();
                check("hit_health", int'(curr_health), e.health);
                check("hit_ko", int'(ko), e.ko);
            end
        end
    end

    task automatic step(input bit nr, input bit hv, input int dmg, input bit blk);
        int ready;
        int eff;
        int alive;
        exp_t e;
        new_round  = nr;
        hit_valid  = hv;
        hit_damage = 8'(dmg);
        blocking   = blk;
        #1;
        ready = (!m_ko && m_lock == 0 && !nr) ? 1 : 0;
        check("hit_ready", int'(hit_ready), ready);
        @(posedge clk);
        alive   = (!m_ko && m_lock == 0) ? 1 : 0;
        m_taken = 0;
        if (nr) begin
            model_reset();
        end else if (ready != 0 && hv) begin
            eff      = blk ? (dmg / 2) : dmg;
            m_health = (m_health > eff) ? m_health - eff : 0;
            m_taken  = 1;
`ifdef HEALTH_REGEN_EN
            m_quiet  = 0;
`endif
            if (m_health == 0) m_ko = 1;
            else               m_lock = INV;
            e.health = m_health;
            e.ko     = m_ko;
            sb_q.push_back(e);
        end else begin
            if (m_lock > 0) m_lock--;
`ifdef HEALTH_REGEN_EN
            if (alive != 0 && m_health < FULL) begin
                m_quiet++;
                if (m_quiet > RD && (m_quiet - RD) % RP == 0) m_health++;
            end else begin
                m_quiet = 0;
            end
`endif
        end
        #1;
        check("curr_health", int'(curr_health), m_health);
        check("ko", int'(ko), m_ko);
        check("invuln", int'(invuln), (m_lock > 0) ? 1 : 0);
        check("hit_taken", int'(hit_taken), m_taken);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0);
    endtask

    task automatic async_reset();
        new_round = 0;
        hit_valid = 0;
        #2 rst_n = 0;
        #1;
        model_reset();
        sb_q.delete();
        check("rst_health", int'(curr_health), FULL);
        check("rst_invuln", int'(invuln), 0);
        check("rst_ko", int'(ko), 0);
        check("rst_hit_taken", int'(hit_taken), 0);
        check("rst_hit_ready", int'(hit_ready), 1);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n      = 0;
        new_round  = 0;
        hit_valid  = 0;
        hit_damage = '0;
        blocking   = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk);
        #1;
        check("init_health", int'(curr_health), FULL);
        check("init_ready", int'(hit_ready), 1);
        check("init_ko", int'(ko), 0);
        check("init_invuln", int'(invuln), 0);

        // 200 -> 170, then a hit held through the window is ignored
        step(0, 1, 30, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 10, 0);
        step(0, 0, 0, 0);
        // Blocked 31 -> 15 damage: 170 -> 155
        step(0, 1, 31, 1);
        idle(4);
        // 155 -> 20 -> KO, held there until new_round
        step(0, 1, 135, 0);
        idle(4);
        step(0, 1, 255, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 5, 0);
        step(1, 0, 0, 0);
        // new_round beats a simultaneous hit at 100
        step(0, 1, 100, 0);
        idle(4);
        step(1, 1, 50, 0);
        idle(1);
        // Zero effective damage still locks out and pulses hit_taken
        step(0, 1, 1, 1);
        idle(5);
        // Async reset mid-invulnerability and in KO
        step(0, 1, 40, 0);
        idle(1);
        async_reset();
        step(0, 1, 200, 0);
        idle(1);
        async_reset();
        // Idle regeneration from 190, then a hit mid-regen
        step(0, 1, 10, 0);
        idle(20);
        step(0, 1, 5, 0);
        idle(40);

        for (int i = 0; i < 600; i++) begin
            int dmg;
            bit nr;
            bit hv;
            nr  = ($urandom_range(0, 39) == 0);
            hv  = ($urandom_range(0, 2) == 0);
            dmg = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 40));
            step(nr, hv, dmg, 1'($urandom_range(0, 1)));
        end

        idle(2);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
